wddl_xor_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one WDDL dual-rail XOR word datapath between two requesters, for example AddRoundKey and key expansion in the AES-256 core. It enforces the WDDL precharge/evaluate discipline: the shared datapath sees all-zero rails on every cycle except a single evaluate cycle per operation. It captures the dual-rail result into a register and returns it over a valid/ready handshake tagged with the requester ID.

---
 rtl/wddl_xor_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wddl_xor_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wddl_xor_arbiter.sv
// rtl/wddl_xor_arbiter.sv - WDDL dual-rail XOR sequencer and two-way round-robin arbiter (optional WDDL_RAIL_CHECK_EN)
module wddl_xor_arbiter #(
   parameter int WORD = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [WORD-1:0] req0_a_t,
   input  logic [WORD-1:0] req0_a_f,
   input  logic [WORD-1:0] req0_b_t,
   input  logic [WORD-1:0] req0_b_f,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [WORD-1:0] req1_a_t,
   input  logic [WORD-1:0] req1_a_f,
   input  logic [WORD-1:0] req1_b_t,
   input  logic [WORD-1:0] req1_b_f,
   output logic [WORD-1:0] xa_t,
   output logic [WORD-1:0] xa_f,
   output logic [WORD-1:0] xb_t,
   output logic [WORD-1:0] xb_f,
   input  logic [WORD-1:0] xo_t,
   input  logic [WORD-1:0] xo_f,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [WORD-1:0] res_t,
   output logic [WORD-1:0] res_f,
   output logic            res_id,
   output logic            fault
);

   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;
   logic            id_q, id_d;
   logic [WORD-1:0] a_t_q, a_t_d, a_f_q, a_f_d;
   logic [WORD-1:0] b_t_q, b_t_d, b_f_q, b_f_d;
   logic [WORD-1:0] res_t_q, res_t_d, res_f_q, res_f_d;

   logic            gnt_any;
   logic            gnt_id;
   logic [WORD-1:0] sel_a_t, sel_a_f, sel_b_t, sel_b_f;
   logic            eval_en;

   // A lone request wins; on a tie the requester not granted last wins
   assign gnt_any = req0_valid | req1_valid;
   assign gnt_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
   assign sel_a_t = gnt_id ? req1_a_t : req0_a_t;
   assign sel_a_f = gnt_id ? req1_a_f : req0_a_f;
   assign sel_b_t = gnt_id ? req1_b_t : req0_b_t;
   assign sel_b_f = gnt_id ? req1_b_f : req0_b_f;

   // Next-state, operand latch, result capture and combinational grant
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      id_d       = id_q;
      a_t_d      = a_t_q;
      a_f_d      = a_f_q;
      b_t_d      = b_t_q;
      b_f_d      = b_f_q;
      res_t_d    = res_t_q;
      res_f_d    = res_f_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               req0_ready = ~gnt_id;
               req1_ready = gnt_id;
               a_t_d      = sel_a_t;
               a_f_d      = sel_a_f;
               b_t_d      = sel_b_t;
               b_f_d      = sel_b_f;
               id_d       = gnt_id;
               last_d     = gnt_id;
               state_d    = EVAL;
            end
         end
         EVAL: begin
            res_t_d = xo_t;
            res_f_d = xo_f;
            a_t_d   = '0;
            a_f_d   = '0;
            b_t_d   = '0;
            b_f_d   = '0;
            state_d = RESP;
         end
         RESP: begin
            if (res_ready) begin
               res_t_d = '0;
               res_f_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pointer, operand and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         a_t_q   <= '0;
         a_f_q   <= '0;
         b_t_q   <= '0;
         b_f_q   <= '0;
         res_t_q <= '0;
         res_f_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         a_t_q   <= a_t_d;
         a_f_q   <= a_f_d;
         b_t_q   <= b_t_d;
         b_f_q   <= b_f_d;
         res_t_q <= res_t_d;
         res_f_q <= res_f_d;
      end
   end

   // Rails are gated so the datapath precharges even if a register glitches
   assign eval_en   = (state_q == EVAL);
   assign xa_t      = {WORD{eval_en}} & a_t_q;
   assign xa_f      = {WORD{eval_en}} & a_f_q;
   assign xb_t      = {WORD{eval_en}} & b_t_q;
   assign xb_f      = {WORD{eval_en}} & b_f_q;
   assign res_valid = (state_q == RESP);
   assign res_t     = {WORD{res_valid}} & res_t_q;
   assign res_f     = {WORD{res_valid}} & res_f_q;
   assign res_id    = id_q;

`ifdef WDDL_RAIL_CHECK_EN
   logic fault_q;
   logic viol;

   // Rail discipline per phase: operands complementary, result complementary, then precharged
   always_comb begin
      viol = 1'b0;
      case (state_q)
         IDLE:    viol = gnt_any && (!(&(sel_a_t ^ sel_a_f)) || !(&(sel_b_t ^ sel_b_f)));
         EVAL:    viol = !(&(xo_t ^ xo_f));
         RESP:    viol = |(xo_t | xo_f);
         default: viol = 1'b0;
      endcase
   end

   // Sticky fault flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fault_q <= 1'b0;
      else     fault_q <= fault_q | viol;
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_xor_arbiter.sv
// tb/tb_wddl_xor_arbiter.sv - scoreboard bench for wddl_xor_arbiter
module tb_wddl_xor_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0] req0_a_t, req0_a_f, req0_b_t, req0_b_f;
   logic [W-1:0] req1_a_t, req1_a_f, req1_b_t, req1_b_f;
   logic [W-1:0] xa_t, xa_f, xb_t, xb_f, xo_t, xo_f;
   logic         res_valid, res_ready, res_id, fault;
   logic [W-1:0] res_t, res_f;

   int n_cmp = 0;
   int n_bad = 0;
   logic [2*W:0] exp_q[$];

   always #5 clk = ~clk;

   // Shared WDDL XOR datapath: precharged inputs give precharged outputs
   assign xo_t = (xa_t & xb_f) | (xa_f & xb_t);
   assign xo_f = (xa_t & xb_t) | (xa_f & xb_f);

   wddl_xor_arbiter #(.WORD(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a_t(req0_a_t), .req0_a_f(req0_a_f), .req0_b_t(req0_b_t), .req0_b_f(req0_b_f),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a_t(req1_a_t), .req1_a_f(req1_a_f), .req1_b_t(req1_b_t), .req1_b_f(req1_b_f),
      .xa_t(xa_t), .xa_f(xa_f), .xb_t(xb_t), .xb_f(xb_f),
      .xo_t(xo_t), .xo_f(xo_f),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_t(res_t), .res_f(res_f), .res_id(res_id), .fault(fault)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic set_req0(input logic [W-1:0] a, input logic [W-1:0] b);
      req0_a_t = a; req0_a_f = ~a; req0_b_t = b; req0_b_f = ~b;
   endtask

   task automatic set_req1(input logic [W-1:0] a, input logic [W-1:0] b);
      req1_a_t = a; req1_a_f = ~a; req1_b_t = b; req1_b_f = ~b;
   endtask

   task automatic push(input logic id, input logic [W-1:0] t, input logic [W-1:0] f);
      exp_q.push_back({id, t, f});
   endtask

   // Monitor: every completed result handshake is popped and compared
   always @(negedge clk) begin
      logic [2*W:0] e;
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got id %0d t %h f %h required none", res_id, res_t, res_f);
         end else begin
            e = exp_q.pop_front();
            chk("res_id", {31'd0, res_id}, {31'd0, e[2*W]});
            chk("res_t", res_t, e[2*W-1:W]);
            chk("res_f", res_f, e[W-1:0]);
         end
      end
   end

   // Watchdog
   initial begin
      #50000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got timeout required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      rst = 1'b1; res_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      set_req0('0, '0); set_req1('0, '0);
      smp; smp;
      chk("rst_xa_t", xa_t | xa_f | xb_t | xb_f, '0);
      chk("rst_res_valid", {31'd0, res_valid}, 0);
      chk("rst_res_t", res_t | res_f, '0);
      chk("rst_res_id", {31'd0, res_id}, 0);
      chk("rst_fault", {31'd0, fault}, 0);
      step; rst = 1'b0;
      smp;
      chk("idle_ready", {30'd0, req1_ready, req0_ready}, 0);

      // Single operation
      step; set_req0(32'hA5A5A5A5, 32'h0F0F0F0F); req0_valid = 1'b1; res_ready = 1'b1;
      smp;
      chk("single_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      chk("single_idle_rails", xa_t | xa_f | xb_t | xb_f, '0);
      push(1'b0, 32'hAAAAAAAA, 32'h55555555);
      step; req0_valid = 1'b0;
      smp;
      chk("eval_xa_t", xa_t, 32'hA5A5A5A5);
      chk("eval_xa_f", xa_f, 32'h5A5A5A5A);
      chk("eval_xb_t", xb_t, 32'h0F0F0F0F);
      chk("eval_res_valid", {31'd0, res_valid}, 0);
      step; smp;
      chk("resp_valid", {31'd0, res_valid}, 1);
      chk("resp_rails", xa_t | xa_f | xb_t | xb_f, '0);
      step; smp;
      chk("after_valid", {31'd0, res_valid}, 0);
      chk("after_res", res_t | res_f, '0);

      // Alternating grants from a fresh pointer
      step; rst = 1'b1;
      step; rst = 1'b0;
      set_req0(32'h12345678, 32'hFFFF0000); set_req1(32'hDEADBEEF, 32'hDEADBEEF);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) step;
         smp;
         if (c % 3 == 0) begin
            if (((c / 3) % 2) == 0) begin
               chk("alt_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
               push(1'b0, 32'hEDCB5678, 32'h1234A987);
            end else begin
               chk("alt_grant1", {30'd0, req1_ready, req0_ready}, 32'd2);
               push(1'b1, 32'h00000000, 32'hFFFFFFFF);
            end
         end else begin
            chk("alt_nogrant", {30'd0, req1_ready, req0_ready}, 0);
         end
      end
      step; req0_valid = 1'b0; req1_valid = 1'b0;
      smp;
      chk("alt_idle", {30'd0, req1_ready, req0_ready}, 0);

      // Back-pressure with a waiting requester
      step; set_req0(32'hFFFFFFFF, 32'h00000000); req0_valid = 1'b1; res_ready = 1'b0;
      smp;
      chk("bp_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      push(1'b0, 32'hFFFFFFFF, 32'h00000000);
      step; req0_valid = 1'b0; set_req1(32'h0F0F0F0F, 32'hA5A5A5A5); req1_valid = 1'b1;
      smp;
      chk("bp_eval_ready", {30'd0, req1_ready, req0_ready}, 0);
      for (int i = 0; i < 5; i++) begin
         step; smp;
         chk("bp_valid", {31'd0, res_valid}, 1);
         chk("bp_res_t", res_t, 32'hFFFFFFFF);
         chk("bp_res_id", {31'd0, res_id}, 0);
         chk("bp_rails", xa_t | xa_f | xb_t | xb_f, '0);
         chk("bp_no_grant", {30'd0, req1_ready, req0_ready}, 0);
      end
      step; res_ready = 1'b1;
      smp;
      chk("bp_release_valid", {31'd0, res_valid}, 1);
      step; smp;
      chk("bp_waiter_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
      push(1'b1, 32'hAAAAAAAA, 32'h55555555);
      step; req1_valid = 1'b0;
      step; step;

      // Reset during EVAL drops the result and restores the pointer
      step; set_req0(32'hA5A5A5A5, 32'h0F0F0F0F); req0_valid = 1'b1;
      smp;
      chk("rst_eval_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      step; req0_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_async_rails", xa_t | xa_f | xb_t | xb_f, '0);
      chk("rst_async_valid", {31'd0, res_valid}, 0);
      chk("rst_async_res", res_t | res_f, '0);
      step; rst = 1'b0;
      set_req1(32'h00000001, 32'h00000003); req0_valid = 1'b1; req1_valid = 1'b1;
      smp;
      chk("rst_tie_req0", {30'd0, req1_ready, req0_ready}, 32'd1);
      push(1'b0, 32'hAAAAAAAA, 32'h55555555);
      step; req0_valid = 1'b0; req1_valid = 1'b0;
      step; step;

      // Rail violation
      step; req0_a_t = 32'hFFFFFFFF; req0_a_f = 32'hFFFFFFFF;
      req0_b_t = 32'h0F0F0F0F; req0_b_f = 32'hF0F0F0F0; req0_valid = 1'b1;
      smp;
      chk("viol_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      push(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      step; req0_valid = 1'b0;
      step; step; smp;
`ifdef WDDL_RAIL_CHECK_EN
      chk("fault_set", {31'd0, fault}, 1);
      step; step; smp;
      chk("fault_sticky", {31'd0, fault}, 1);
`else
      chk("fault_tied", {31'd0, fault}, 0);
`endif
      step; rst = 1'b1;
      smp;
      chk("fault_rst", {31'd0, fault}, 0);
      step; rst = 1'b0;

      step; smp;
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
